// File: rtl/vga_pkg.sv
// Shared video constants and helpers for blocks that sample the composed VGA stream.
package vga_pkg;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned RGB_W   = 12;

    localparam logic [RGB_W-1:0] DUCK_KEY_RGB = 12'h8_4_2;
    localparam logic [RGB_W-1:0] KEY_MASK     = 12'hF_F_0;

    // Lower window edge, clamped at the left/top of the screen instead of wrapping.
    function automatic logic [COORD_W-1:0] clip_lo(input logic [COORD_W-1:0] c,
                                                   input logic [COORD_W-1:0] r);
        return (c >= r) ? (c - r) : '0;
    endfunction

    // Upper window edge, one bit wider so coordinates near 4095 cannot wrap.
    function automatic logic [COORD_W:0] ext_hi(input logic [COORD_W-1:0] c,
                                                input logic [COORD_W-1:0] r);
        return {1'b0, c} + {1'b0, r};
    endfunction

endpackage

// File: rtl/vga_if.sv
// Composed VGA stream: raster position, blanking, syncs and pixel colour.
interface vga_if;
    import vga_pkg::*;

    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic [RGB_W-1:0]   rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/hit_window_match.sv
// Combinational test of one pixel: inside the shot window, and colour equal to the key.
module hit_window_match
    import vga_pkg::*;
(
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    input  logic               hblnk,
    input  logic               vblnk,
    input  logic [RGB_W-1:0]   rgb,
    input  logic [COORD_W-1:0] x_lo,
    input  logic [COORD_W:0]   x_hi,
    input  logic [COORD_W-1:0] y_lo,
    input  logic [COORD_W:0]   y_hi,
    output logic               in_window,
    output logic               match
);

    logic w_x_in;
    logic w_y_in;
    logic w_key;

    assign w_x_in    = (hcount >= x_lo) && ({1'b0, hcount} <= x_hi);
    assign w_y_in    = (vcount >= y_lo) && ({1'b0, vcount} <= y_hi);
    assign w_key     = ((rgb & KEY_MASK) == (DUCK_KEY_RGB & KEY_MASK));
    assign in_window = !hblnk && !vblnk && w_x_in && w_y_in;
    assign match     = in_window && w_key;

endmodule

// File: rtl/hit_detector.sv
// Light-gun hit detector: counts key-coloured pixels in a square window around the
// cursor over one complete frame and reports hit / count / timeout with a handshake.
//
//   state      | meaning
//   IDLE       | waiting for shot_req
//   WAIT_FRAME | window latched, waiting for vblnk rising edge
//   SCAN       | counting matching pixels until window end or frame timeout
//   RESULT     | outputs held until hit_ack
module hit_detector
    import vga_pkg::*;
#(
    parameter  int HIT_RADIUS     = 2,
    parameter  int HIT_MIN        = 3,
    parameter  int TIMEOUT_FRAMES = 2,
    localparam int CNT_W          = $clog2((2*HIT_RADIUS+1)**2+1)
)(
    input  logic               clk,
    input  logic               rst_n,
    vga_if.in                  in,
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    input  logic               shot_req,
    output logic               shot_busy,
    output logic               hit_valid,
    output logic               hit,
    output logic [CNT_W-1:0]   hit_count,
    output logic               timeout,
    input  logic               hit_ack
);

    localparam int               FRM_W   = $clog2(TIMEOUT_FRAMES+1);
    localparam logic [COORD_W-1:0] RAD   = COORD_W'(HIT_RADIUS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        SCAN,
        RESULT
    } state_t;

    state_t             r_state;
    logic               r_vblnk_d;
    logic [COORD_W-1:0] r_x_lo;
    logic [COORD_W:0]   r_x_hi;
    logic [COORD_W-1:0] r_y_lo;
    logic [COORD_W:0]   r_y_hi;
    logic [CNT_W-1:0]   r_count;
    logic [FRM_W-1:0]   r_frames;

    logic               w_in_window;
    logic               w_match;
    logic               w_vblnk_rise;
    logic               w_finish;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [FRM_W-1:0]   w_frames_next;
    logic               w_hit_next;
    logic               w_frames_done;

    hit_window_match u_match (
        .hcount    (in.hcount),
        .vcount    (in.vcount),
        .hblnk     (in.hblnk),
        .vblnk     (in.vblnk),
        .rgb       (in.rgb),
        .x_lo      (r_x_lo),
        .x_hi      (r_x_hi),
        .y_lo      (r_y_lo),
        .y_hi      (r_y_hi),
        .in_window (w_in_window),
        .match     (w_match)
    );

    assign w_vblnk_rise  = in.vblnk && !r_vblnk_d;
    // Last row of the window ends either at x_hi or, if clipped by the line, at hblnk.
    assign w_finish      = ({1'b0, in.vcount} == r_y_hi) &&
                           (({1'b0, in.hcount} == r_x_hi) || in.hblnk);
    assign w_cnt_next    = (w_match && (r_count != CNT_MAX)) ? r_count + 1'b1 : r_count;
    assign w_hit_next    = (32'(w_cnt_next) >= 32'(HIT_MIN));
    assign w_frames_next = r_frames + 1'b1;
    assign w_frames_done = (32'(w_frames_next) >= 32'(TIMEOUT_FRAMES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_vblnk_d <= 1'b0;
            r_x_lo    <= '0;
            r_x_hi    <= '0;
            r_y_lo    <= '0;
            r_y_hi    <= '0;
            r_count   <= '0;
            r_frames  <= '0;
            shot_busy <= 1'b0;
            hit_valid <= 1'b0;
            hit       <= 1'b0;
            hit_count <= '0;
            timeout   <= 1'b0;
        end else begin
            r_vblnk_d <= in.vblnk;
            case (r_state)
                IDLE: begin
                    if (shot_req) begin
                        r_x_lo    <= clip_lo(xpos, RAD);
                        r_x_hi    <= ext_hi(xpos, RAD);
                        r_y_lo    <= clip_lo(ypos, RAD);
                        r_y_hi    <= ext_hi(ypos, RAD);
                        r_count   <= '0;
                        r_frames  <= '0;
                        shot_busy <= 1'b1;
                        r_state   <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (w_vblnk_rise) begin
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_count <= w_cnt_next;
                    if (w_finish) begin
                        hit_valid <= 1'b1;
                        hit       <= w_hit_next;
                        hit_count <= w_cnt_next;
                        timeout   <= 1'b0;
                        r_state   <= RESULT;
                    end else if (w_vblnk_rise) begin
                        r_frames <= w_frames_next;
                        if (w_frames_done) begin
                            hit_valid <= 1'b1;
                            hit       <= 1'b0;
                            hit_count <= w_cnt_next;
                            timeout   <= 1'b1;
                            r_state   <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (hit_ack) begin
                        hit_valid <= 1'b0;
                        shot_busy <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hit_detector.sv
// Directed bench for hit_detector: a compact raster viewport is streamed, expected
// results are queued per shot and a separate monitor checks each presented result.
module tb_hit_detector;
    import vga_pkg::*;

    localparam int CW = 5;
    localparam int HA = 24;
    localparam int HT = 28;
    localparam int VA = 24;
    localparam int VT = 26;

    typedef struct {
        logic          hit;
        logic [CW-1:0] cnt;
        logic          to;
        bit            chk_pos;
        int            fh;
        int            fv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_if vif ();

    logic [11:0]   xpos = '0;
    logic [11:0]   ypos = '0;
    logic          shot_req = 1'b0;
    logic          hit_ack = 1'b0;
    logic          shot_busy;
    logic          hit_valid;
    logic          hit;
    logic [CW-1:0] hit_count;
    logic          timeout;

    hit_detector #(.HIT_RADIUS(2), .HIT_MIN(3), .TIMEOUT_FRAMES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (vif),
        .xpos      (xpos),
        .ypos      (ypos),
        .shot_req  (shot_req),
        .shot_busy (shot_busy),
        .hit_valid (hit_valid),
        .hit       (hit),
        .hit_count (hit_count),
        .timeout   (timeout),
        .hit_ack   (hit_ack)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Raster viewport: real frame coordinates starting at (h0,v0), short blanking.
    logic [11:0] h0 = '0;
    logic [11:0] v0 = '0;
    int          pat = 0;
    int          hi = 0;
    int          vi = 0;

    function automatic logic [11:0] pixel(input int h, input int v, input int p);
        logic odd;
        odd = ((h + v) % 2) == 1;
        if (p == 1) return odd ? 12'h84A : 12'h842;
        if (h >= 100 && h <= 109 && v >= 200 && v <= 209) return odd ? 12'h84A : 12'h842;
        return odd ? 12'h852 : 12'h942;
    endfunction

    task automatic drive_vga();
        vif.hcount = h0 + 12'(hi);
        vif.vcount = v0 + 12'(vi);
        vif.hblnk  = (hi >= HA);
        vif.vblnk  = (vi >= VA);
        vif.hsync  = (hi == HA + 1) || (hi == HA + 2);
        vif.vsync  = (vi == VA + 1);
        vif.rgb    = (hi >= HA || vi >= VA) ? 12'h000 : pixel(int'(vif.hcount), int'(vif.vcount), pat);
    endtask

    initial begin
        drive_vga();
        forever begin
            @(negedge clk);
            if (hi == HT - 1) begin
                hi = 0;
                vi = (vi == VT - 1) ? 0 : vi + 1;
            end else begin
                hi = hi + 1;
            end
            drive_vga();
        end
    end

    // Monitor: pop on each new result, then require it to stay put until ack.
    initial begin
        bit   prev_valid;
        bit   have_exp;
        exp_t cur;
        prev_valid = 1'b0;
        have_exp   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
                have_exp   = 1'b0;
            end else begin
                if (hit_valid && !prev_valid) begin
                    if (sbq.size() == 0) begin
                        have_exp = 1'b0;
                        check("unexpected_result", 1, 0);
                    end else begin
                        cur      = sbq.pop_front();
                        have_exp = 1'b1;
                        check("res_hit", int'(hit), int'(cur.hit));
                        check("res_count", int'(hit_count), int'(cur.cnt));
                        check("res_timeout", int'(timeout), int'(cur.to));
                        check("res_busy", int'(shot_busy), 1);
                        if (cur.chk_pos) begin
                            check("latency_h", int'(vif.hcount), cur.fh);
                            check("latency_v", int'(vif.vcount), cur.fv);
                        end
                    end
                end else if (hit_valid && prev_valid && have_exp) begin
                    check("hold_hit", int'(hit), int'(cur.hit));
                    check("hold_count", int'(hit_count), int'(cur.cnt));
                    check("hold_timeout", int'(timeout), int'(cur.to));
                end
                prev_valid = hit_valid;
            end
        end
    end

    task automatic wait_level(input logic lvl, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (vif.vblnk == lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check({name, "_vblnk_wait"}, 0, 1);
    endtask

    // Wait until the DUT has certainly entered SCAN, then a little into the frame.
    task automatic wait_in_scan(input string name);
        wait_level(1'b0, name);
        wait_level(1'b1, name);
        wait_level(1'b0, name);
        repeat (30) @(negedge clk);
    endtask

    task automatic set_view(input logic [11:0] nh, input logic [11:0] nv, input int p);
        @(negedge clk);
        h0  = nh;
        v0  = nv;
        pat = p;
    endtask

    // Called at a negedge; the request is sampled at the next posedge.
    task automatic start_shot(input logic [11:0] x, input logic [11:0] y, input string name);
        xpos     = x;
        ypos     = y;
        shot_req = 1'b1;
        @(negedge clk);
        shot_req = 1'b0;
        check({name, "_busy_next"}, int'(shot_busy), 1);
    endtask

    task automatic finish_shot(input int ack_delay, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (hit_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check({name, "_valid_seen"}, 0, 1);
            rst_n = 1'b0;
            @(negedge clk);
            sbq.delete();
            rst_n = 1'b1;
        end else begin
            repeat (ack_delay) @(negedge clk);
            hit_ack = 1'b1;
            @(negedge clk);
            hit_ack = 1'b0;
            check({name, "_valid_after_ack"}, int'(hit_valid), 0);
            check({name, "_busy_after_ack"}, int'(shot_busy), 0);
        end
    endtask

    task automatic shot(input logic [11:0] x, input logic [11:0] y, input exp_t e,
                        input int ack_delay, input string name);
        @(negedge clk);
        sbq.push_back(e);
        start_shot(x, y, name);
        finish_shot(ack_delay, name);
    endtask

    function automatic exp_t mk(input logic h, input int c, input logic t,
                                input bit p, input int fh, input int fv);
        exp_t e;
        e.hit = h; e.cnt = CW'(c); e.to = t; e.chk_pos = p; e.fh = fh; e.fv = fv;
        return e;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", int'(shot_busy), 0);
        check("rst_valid", int'(hit_valid), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_count", int'(hit_count), 0);
        check("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;

        // First request in the cycle right after reset release.
        set_view(12'd94, 12'd194, 0);
        sbq.push_back(mk(1'b1, 25, 1'b0, 1'b1, 107, 207));
        start_shot(12'd105, 12'd205, "center");
        finish_shot(2, "center");

        // Stray ack while idle must do nothing.
        @(negedge clk);
        hit_ack = 1'b1;
        @(negedge clk);
        hit_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_valid", int'(hit_valid), 0);
        check("idle_ack_busy", int'(shot_busy), 0);

        set_view(12'd290, 12'd290, 0);
        shot(12'd300, 12'd300, mk(1'b0, 0, 1'b0, 1'b1, 302, 302), 2, "miss");

        set_view(12'd90, 12'd194, 0);
        shot(12'd100, 12'd205, mk(1'b1, 15, 1'b0, 1'b1, 102, 207), 2, "edge");

        set_view(12'd90, 12'd190, 0);
        shot(12'd99, 12'd198, mk(1'b0, 2, 1'b0, 1'b1, 101, 200), 2, "min_minus1");
        shot(12'd100, 12'd198, mk(1'b1, 3, 1'b0, 1'b1, 102, 200), 2, "min_exact");

        set_view(12'd0, 12'd0, 1);
        shot(12'd1, 12'd1, mk(1'b1, 16, 1'b0, 1'b1, 3, 3), 2, "clip");

        set_view(12'd0, 12'd0, 0);
        shot(12'd4000, 12'd4000, mk(1'b0, 0, 1'b1, 1'b0, 0, 0), 2, "timeout");

        // Extra request and stray ack during SCAN are ignored: one result only.
        set_view(12'd94, 12'd194, 0);
        @(negedge clk);
        sbq.push_back(mk(1'b1, 25, 1'b0, 1'b1, 107, 207));
        start_shot(12'd105, 12'd205, "dbl");
        wait_in_scan("dbl");
        check("dbl_busy_scan", int'(shot_busy), 1);
        xpos     = 12'd300;
        ypos     = 12'd300;
        shot_req = 1'b1;
        @(negedge clk);
        shot_req = 1'b0;
        hit_ack  = 1'b1;
        @(negedge clk);
        hit_ack  = 1'b0;
        finish_shot(2, "dbl");
        repeat (1600) @(negedge clk);
        check("dbl_no_second_busy", int'(shot_busy), 0);
        check("dbl_no_second_valid", int'(hit_valid), 0);

        shot(12'd105, 12'd205, mk(1'b1, 25, 1'b0, 1'b1, 107, 207), 100, "hold");

        // Reset mid-SCAN, then a fresh shot in the cycle after release.
        @(negedge clk);
        start_shot(12'd105, 12'd205, "rstscan");
        wait_in_scan("rstscan");
        rst_n = 1'b0;
        @(negedge clk);
        check("rstscan_busy", int'(shot_busy), 0);
        check("rstscan_valid", int'(hit_valid), 0);
        check("rstscan_hit", int'(hit), 0);
        check("rstscan_count", int'(hit_count), 0);
        check("rstscan_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        @(negedge clk);
        sbq.push_back(mk(1'b1, 25, 1'b0, 1'b1, 107, 207));
        start_shot(12'd105, 12'd205, "after_rst");
        finish_shot(2, "after_rst");

        repeat (20) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hit_detector.md
HIT_DETECTOR -- requirements
Module: hit_detector

Interface
REQ-001 The block SHALL have parameter HIT_RADIUS, default 2, half-width in pixels of the square sample window.
REQ-002 The block SHALL have parameter HIT_MIN, default 3, the minimum number of matching pixels that counts as a hit.
REQ-003 The block SHALL have parameter TIMEOUT_FRAMES, default 2, the number of frame starts after which a shot is abandoned.
REQ-004 The block SHALL have the following ports:
- clk  in  1  system pixel clock; only clock.
- rst_n  in  1  reset, synchronous, active-low.
- in  vga_if.in  --  composed video stream to sample; read-only, no pass-through.
- xpos  in  12  cursor x at time of shot.
- ypos  in  12  cursor y at time of shot.
- shot_req  in  1  single-cycle shot request.
- shot_busy  out  1  high from request acceptance until result acknowledged.
- hit_valid  out  1  result available.
- hit  out  1  match count >= HIT_MIN.
- hit_count  out  $clog2((2*HIT_RADIUS+1)**2+1)  matching pixels in window.
- timeout  out  1  window never completed.
- hit_ack  in  1  consumer acknowledge of result.

Function
REQ-005 The FSM SHALL have states IDLE, WAIT_FRAME, SCAN, RESULT.
REQ-006 IDLE: on shot_req=1, the block SHALL latch x_lo=max(xpos-HIT_RADIUS,0), x_hi=xpos+HIT_RADIUS, y_lo=max(ypos-HIT_RADIUS,0), y_hi=ypos+HIT_RADIUS, clear count/frame counters, go to WAIT_FRAME, and assert shot_busy the next cycle.
REQ-007 The block SHALL ignore shot_req in any state other than IDLE, with no side effects.
REQ-008 WAIT_FRAME: on a rising edge of in.vblnk (registered previous value), the FSM SHALL go to SCAN, so sampling always starts on a complete frame.
REQ-009 SCAN: each cycle with !in.hblnk, !in.vblnk, x_lo<=in.hcount<=x_hi and y_lo<=in.vcount<=y_hi, the block SHALL increment the match counter if (in.rgb & KEY_MASK)==(DUCK_KEY_RGB & KEY_MASK).
REQ-010 The counter SHALL saturate at its maximum and never wrap.
REQ-011 SCAN SHALL finish at the first cycle with in.vcount==y_hi and (in.hcount==x_hi or in.hblnk=1); that cycle's pixel SHALL be included. The FSM SHALL then go to RESULT with timeout=0.
REQ-012 SCAN SHALL count in.vblnk rising edges; on reaching TIMEOUT_FRAMES it SHALL go to RESULT with timeout=1, hit=0, and hit_count set to the count so far.
REQ-013 hit_valid, hit, hit_count and timeout SHALL be registered and valid the cycle after the finishing pixel (latency 1 clk).
REQ-014 RESULT: outputs SHALL hold stable while hit_valid=1. On hit_ack=1, the FSM SHALL go to IDLE, with hit_valid and shot_busy low the next cycle.
REQ-015 hit_ack outside RESULT SHALL be ignored.
REQ-016 A shot_req arriving in the same cycle as hit_ack SHALL be ignored.
REQ-017 hit SHALL equal (hit_count >= HIT_MIN) && !timeout.

Reset
REQ-018 rst_n=0 at a clk edge SHALL force IDLE and set shot_busy, hit_valid, hit, timeout to 0 and hit_count, latched window and frame counter to 0, including mid-SCAN or mid-RESULT.
REQ-019 The first shot_req SHALL be accepted in the cycle after rst_n returns to 1.

Structure
REQ-020 DUCK_KEY_RGB (default 12'h8_4_2) and KEY_MASK (default 12'hF_F_0) SHALL live in vga_pkg.
REQ-021 The state enum SHALL be local to the module.
REQ-022 The combinational window-membership and colour-compare logic SHALL be one sub-module, hit_window_match, with inputs hcount, vcount, hblnk, vblnk, rgb and window bounds, and output in_window and match.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Static frame with a 10x10 key-colour block at (100..109,200..209); shot at (105,205), HIT_RADIUS=2 -> hit_valid with hit=1, hit_count=25, timeout=0.
- Same frame, shot at (300,300) -> hit=0, hit_count=0, timeout=0.
- Block edge at x=100; shot at (100,205) -> hit_count=15, hit=1.
- Shot at (1,1) -> window clipped to 0..3 x 0..3, hit_count<=16.
- Shot at (4000,4000) -> timeout=1, hit=0 after 2 frame starts.
- Second shot_req during SCAN -> ignored, single result.
- hit_ack withheld 100 cycles -> outputs stable throughout.
- rst_n=0 mid-SCAN -> all outputs 0 next cycle; a new shot then completes normally.
